// File: rtl/o_drain_writer_if.sv
// Signal bundle between the O-buffer drain writer (master) and its environment:
// the system controller, the O buffer read port and the output BRAM write port.
interface o_drain_writer_if #(
  parameter int ARRAY_M    = 16,
  parameter int RAM_SIZE   = 1024,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int OUT_WIDTH  = 32
);
  localparam int IDX_WIDTH = (ARRAY_M > 1) ? $clog2(ARRAY_M) : 1;

  logic                  start;
  logic [ADDR_WIDTH:0]   num_rows;
  logic [IDX_WIDTH:0]    num_cols;
  logic [ADDR_WIDTH-1:0] o_base_addr;
  logic [31:0]           bram_base_addr;
  logic [31:0]           row_stride;
  logic [IDX_WIDTH-1:0]  o_ram_idx;
  logic [ADDR_WIDTH-1:0] o_read_addr;
  logic [OUT_WIDTH-1:0]  data_read;
  logic [31:0]           bram_w_addr;
  logic [31:0]           bram_w_data;
  logic [3:0]            bram_w_en;
  logic                  bram_w_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, num_rows, num_cols, o_base_addr, bram_base_addr, row_stride,
    input  data_read, bram_w_ready,
    output o_ram_idx, o_read_addr, bram_w_addr, bram_w_data, bram_w_en, busy, done
  );

  modport slave (
    output start, num_rows, num_cols, o_base_addr, bram_base_addr, row_stride,
    output data_read, bram_w_ready,
    input  o_ram_idx, o_read_addr, bram_w_addr, bram_w_data, bram_w_en, busy, done
  );
endinterface

// File: rtl/o_drain_writer.sv
// Drains one tile from the column-banked O buffer into the output BRAM in row-major order:
// address the buffer, wait out its read latency, then write the word with a ready handshake.
module o_drain_writer #(
  parameter int ARRAY_M    = 16,
  parameter int RAM_SIZE   = 1024,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int OUT_WIDTH  = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  o_drain_writer_if.master bus
);
  localparam int IDX_WIDTH = (ARRAY_M > 1) ? $clog2(ARRAY_M) : 1;
  localparam int CW        = IDX_WIDTH + 1;
  localparam int RW        = ADDR_WIDTH + 1;
  localparam logic [2:0]    WAIT_LAST  = 3'(RD_LATENCY - 1);
  localparam logic [RW-1:0] RAM_SIZE_W = RW'(RAM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [RW-1:0]         rows_q;
  logic [RW-1:0]         row_q;
  logic [CW-1:0]         cols_q;
  logic [CW-1:0]         col_q;
  logic [31:0]           stride_q;
  logic [31:0]           row_byte_q;
  logic [31:0]           w_addr_q;
  logic [ADDR_WIDTH-1:0] rd_row_q;
  logic [ADDR_WIDTH-1:0] read_addr_q;
  logic [IDX_WIDTH-1:0]  ram_idx_q;
  logic [2:0]            wait_q;
  logic [OUT_WIDTH-1:0]  data_q;
  logic [3:0]            w_en_q;
  logic                  busy_q;
  logic                  done_q;

  logic [CW-1:0]         col_inc;
  logic [RW-1:0]         row_inc;
  logic                  col_last;
  logic                  row_last;
  logic [ADDR_WIDTH-1:0] start_rd_addr;
  logic [ADDR_WIDTH-1:0] next_rd_addr;
  logic [31:0]           next_row_byte;

  // Operand never exceeds 2*RAM_SIZE-1, so one conditional subtraction is a full modulo.
  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [RW-1:0] a);
    if (a >= RAM_SIZE_W) begin
      return ADDR_WIDTH'(a - RAM_SIZE_W);
    end
    return ADDR_WIDTH'(a);
  endfunction

  always_comb begin
    col_inc       = col_q + CW'(1);
    row_inc       = row_q + RW'(1);
    col_last      = (col_inc == cols_q);
    row_last      = (row_inc == rows_q);
    start_rd_addr = wrap_addr({1'b0, bus.o_base_addr});
    next_rd_addr  = wrap_addr({1'b0, rd_row_q} + RW'(1));
    next_row_byte = row_byte_q + stride_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      row_q       <= '0;
      cols_q      <= '0;
      col_q       <= '0;
      stride_q    <= '0;
      row_byte_q  <= '0;
      w_addr_q    <= '0;
      rd_row_q    <= '0;
      read_addr_q <= '0;
      ram_idx_q   <= '0;
      wait_q      <= '0;
      data_q      <= '0;
      w_en_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            rows_q     <= bus.num_rows;
            cols_q     <= bus.num_cols;
            stride_q   <= bus.row_stride;
            rd_row_q   <= start_rd_addr;
            row_byte_q <= bus.bram_base_addr;
            row_q      <= '0;
            col_q      <= '0;
            busy_q     <= 1'b1;
            if (bus.num_rows == '0 || bus.num_cols == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              // Buffer-side outputs are registered so they are valid throughout ISSUE.
              state_q     <= S_ISSUE;
              ram_idx_q   <= '0;
              read_addr_q <= start_rd_addr;
              w_addr_q    <= bus.bram_base_addr;
            end
          end
        end

        S_ISSUE: begin
          state_q <= S_WAIT;
          wait_q  <= '0;
        end

        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            data_q  <= bus.data_read;
            w_en_q  <= 4'hF;
            state_q <= S_WRITE;
          end else begin
            wait_q <= wait_q + 3'd1;
          end
        end

        S_WRITE: begin
          if (bus.bram_w_ready) begin
            w_en_q <= '0;
            if (!col_last) begin
              col_q     <= col_inc;
              ram_idx_q <= col_inc[IDX_WIDTH-1:0];
              w_addr_q  <= w_addr_q + 32'd4;
              state_q   <= S_ISSUE;
            end else if (!row_last) begin
              // Row change: running bases replace any row*stride product.
              col_q       <= '0;
              ram_idx_q   <= '0;
              row_q       <= row_inc;
              rd_row_q    <= next_rd_addr;
              read_addr_q <= next_rd_addr;
              row_byte_q  <= next_row_byte;
              w_addr_q    <= next_row_byte;
              state_q     <= S_ISSUE;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ram_idx   = ram_idx_q;
  assign bus.o_read_addr = read_addr_q;
  assign bus.bram_w_addr = w_addr_q;
  assign bus.bram_w_en   = w_en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

  generate
    if (OUT_WIDTH >= 32) begin : g_data_wide
      assign bus.bram_w_data = data_q[31:0];
    end else begin : g_data_narrow
      assign bus.bram_w_data = {{(32 - OUT_WIDTH){1'b0}}, data_q};
    end
  endgenerate
endmodule

// File: tb/tb_o_drain_writer.sv
// Bench for o_drain_writer: two instances (read latency 1 and 3) against an O-buffer memory
// model and a row-major write-list reference computed with plain arithmetic.
`timescale 1ns/1ps
module tb_o_drain_writer;
  localparam int ARRAY_M  = 16;
  localparam int RAM_SIZE = 1024;
  localparam int AW       = 10;
  localparam int OUT_W    = 32;

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] d;
    int          hold;
    int          t;
  } wr_t;

  logic clk = 1'b0;
  logic rst1_n = 1'b1;
  logic rst3_n = 1'b1;
  always #5 clk = ~clk;

  o_drain_writer_if #(.ARRAY_M(ARRAY_M), .RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(AW), .OUT_WIDTH(OUT_W)) bus1 ();
  o_drain_writer_if #(.ARRAY_M(ARRAY_M), .RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(AW), .OUT_WIDTH(OUT_W)) bus3 ();

  o_drain_writer #(.ARRAY_M(ARRAY_M), .RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(AW), .OUT_WIDTH(OUT_W), .RD_LATENCY(1))
    dut1 (.clk(clk), .reset(rst1_n), .bus(bus1));
  o_drain_writer #(.ARRAY_M(ARRAY_M), .RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(AW), .OUT_WIDTH(OUT_W), .RD_LATENCY(3))
    dut3 (.clk(clk), .reset(rst3_n), .bus(bus3));

  // O buffer model: column-banked memory with a fixed read pipeline per instance.
  logic [31:0] mem [ARRAY_M][RAM_SIZE];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  always @(posedge clk) begin
    pipe1    <= mem[bus1.o_ram_idx][bus1.o_read_addr];
    pipe3[0] <= mem[bus3.o_ram_idx][bus3.o_read_addr];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus1.data_read = pipe1;
  assign bus3.data_read = pipe3[2];

  int tests = 0;
  int fails = 0;

  // Monitor state (written only by the negedge monitor)
  wr_t         wq[$];
  int          cyc = 0;
  int          nacc[2];
  int          dn[2];
  int          dt[2];
  int          bz[2];
  int          hold[2];
  int          unst[2];
  int          bad_en[2];
  logic [31:0] ha[2];
  logic [31:0] hd[2];

  // Ready-generator controls (written by the stimulus) and state (ready process only)
  int rmode[2];
  int stall_idx[2];
  int stall_len[2];
  int acc_base[2];
  int scnt[2];

  task automatic mon(input int k, input logic [3:0] en, input logic rdy, input logic [31:0] a,
                     input logic [31:0] d, input logic bsy, input logic dn_i);
    if (en == 4'hF) begin
      if (hold[k] == 0) begin
        ha[k] = a;
        hd[k] = d;
      end else if (a !== ha[k] || d !== hd[k]) begin
        unst[k]++;
      end
      hold[k]++;
      if (rdy === 1'b1) begin
        wq.push_back('{k, a, d, hold[k], cyc});
        nacc[k]++;
        hold[k] = 0;
      end
    end else begin
      hold[k] = 0;
      if (en !== 4'h0) bad_en[k]++;
    end
    if (dn_i === 1'b1) begin
      dn[k]++;
      dt[k] = cyc;
    end
    if (bsy === 1'b1) bz[k]++;
  endtask

  always @(negedge clk) begin
    cyc++;
    mon(0, bus1.bram_w_en, bus1.bram_w_ready, bus1.bram_w_addr, bus1.bram_w_data, bus1.busy, bus1.done);
    mon(1, bus3.bram_w_en, bus3.bram_w_ready, bus3.bram_w_addr, bus3.bram_w_data, bus3.busy, bus3.done);
  end

  task automatic rdy_for(input int k, input logic [3:0] en, output logic r);
    r = 1'b1;
    if (en != 4'hF) scnt[k] = 0;
    if (rmode[k] == 1) begin
      r = 1'($urandom_range(0, 1));
    end else if (rmode[k] == 2 && en == 4'hF && (nacc[k] - acc_base[k]) == stall_idx[k] &&
                 scnt[k] < stall_len[k]) begin
      r = 1'b0;
      scnt[k]++;
    end
  endtask

  logic r0, r1;
  always @(posedge clk) begin
    #1;
    rdy_for(0, bus1.bram_w_en, r0);
    rdy_for(1, bus3.bram_w_en, r1);
    bus1.bram_w_ready = r0;
    bus3.bram_w_ready = r1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int rows, input int cols, input logic [31:0] ob, input logic [31:0] bb,
                        input logic [31:0] st);
    bus1.num_rows = 11'(rows);  bus3.num_rows = 11'(rows);
    bus1.num_cols = 5'(cols);   bus3.num_cols = 5'(cols);
    bus1.o_base_addr = 10'(ob); bus3.o_base_addr = 10'(ob);
    bus1.bram_base_addr = bb;   bus3.bram_base_addr = bb;
    bus1.row_stride = st;       bus3.row_stride = st;
  endtask

  task automatic drive_start(input int k, input logic v);
    if (k == 0) bus1.start = v;
    else        bus3.start = v;
  endtask

  // One transfer on instance k; xs>0 fires a second (ignored) start xs cycles after the first.
  task automatic run(input int k, input int rows, input int cols, input logic [31:0] ob,
                     input logic [31:0] bb, input logic [31:0] st, input int mode, input int xs,
                     input string tag);
    int w0, d0, b0, u0, e0, s, n, lat, idx, extra, exp_cyc, exp_hold;
    logic [31:0] ea, ed;
    wr_t got[$];
    lat = (k == 0) ? 1 : 3;
    rmode[k] = mode;
    acc_base[k] = nacc[k];
    w0 = wq.size(); d0 = dn[k]; b0 = bz[k]; u0 = unst[k]; e0 = bad_en[k];
    set_in(rows, cols, ob, bb, st);
    @(posedge clk); #1; drive_start(k, 1'b1);
    @(posedge clk); s = cyc; #1; drive_start(k, 1'b0);
    if (xs > 0) begin
      repeat (xs) @(posedge clk);
      #1; set_in(4, 5, 32'h0, 32'hDEAD0000, 32'd8); drive_start(k, 1'b1);
      @(posedge clk); #1; drive_start(k, 1'b0);
    end
    n = 0;
    while (dn[k] == d0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(dn[k] != d0), 64'd1);
    repeat (6) @(posedge clk);
    for (int i = w0; i < wq.size(); i++) if (wq[i].k == k) got.push_back(wq[i]);
    chk({tag, "_count"}, 64'(got.size()), 64'(rows * cols));
    idx = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        ea = bb + 32'(r) * st + 32'(c * 4);
        ed = mem[c][(32'(ob) + 32'(r)) % RAM_SIZE];
        if (idx < got.size()) begin
          chk($sformatf("%s_addr%0d", tag, idx), 64'(got[idx].a), 64'(ea));
          chk($sformatf("%s_data%0d", tag, idx), 64'(got[idx].d), 64'(ed));
          exp_hold = (mode == 2 && idx == stall_idx[k]) ? stall_len[k] + 1 : ((mode == 1) ? -1 : 1);
          if (exp_hold > 0) chk($sformatf("%s_hold%0d", tag, idx), 64'(got[idx].hold), 64'(exp_hold));
          if (mode == 0 && idx > 0)
            chk($sformatf("%s_spacing%0d", tag, idx), 64'(got[idx].t - got[idx-1].t), 64'(2 + lat));
        end
        idx++;
      end
    end
    chk({tag, "_done_once"}, 64'(dn[k] - d0), 64'd1);
    chk({tag, "_stable"}, 64'(unst[k] - u0), 64'd0);
    chk({tag, "_en_legal"}, 64'(bad_en[k] - e0), 64'd0);
    if (mode != 1) begin
      extra = (mode == 2) ? stall_len[k] : 0;
      exp_cyc = rows * cols * (2 + lat) + 1 + extra;
      chk({tag, "_done_cycle"}, 64'(dt[k] - s), 64'(exp_cyc));
      chk({tag, "_busy_cycles"}, 64'(bz[k] - b0), 64'(exp_cyc));
    end
    $display("[TB] %s: lat=%0d rows=%0d cols=%0d writes=%0d done_cycle=%0d", tag, lat, rows, cols,
             got.size(), dt[k] - s);
  endtask

  initial begin
    int n, w0, d0, rows, cols, k;
    logic [AW-1:0] ra0;
    logic [31:0] ob, bb, st;

    bus1.start = 1'b0; bus3.start = 1'b0;
    set_in(0, 0, 0, 0, 0);
    for (int c = 0; c < ARRAY_M; c++)
      for (int a = 0; a < RAM_SIZE; a++) mem[c][a] = $urandom;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) mem[c][16 + r] = 32'hA0 + 32'(10 * r + c);

    #2; rst1_n = 1'b0; rst3_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus1.busy), 64'd0);
    chk("rst_done", 64'(bus1.done), 64'd0);
    chk("rst_en", 64'(bus1.bram_w_en), 64'd0);
    chk("rst_raddr", 64'(bus1.o_read_addr), 64'd0);
    chk("rst_ridx", 64'(bus1.o_ram_idx), 64'd0);
    chk("rst_waddr", 64'(bus1.bram_w_addr), 64'd0);
    chk("rst_wdata", 64'(bus1.bram_w_data), 64'd0);
    chk("rst3_busy", 64'(bus3.busy), 64'd0);
    @(negedge clk); rst1_n = 1'b1; rst3_n = 1'b1;
    repeat (2) @(posedge clk);

    run(0, 2, 3, 32'h10, 32'h100, 32'd12, 0, 0, "base");
    chk("base_last_addr", 64'(wq[wq.size()-1].a), 64'h114);
    chk("base_last_data", 64'(wq[wq.size()-1].d), 64'hAC);

    stall_idx[0] = 1; stall_len[0] = 5;
    run(0, 2, 3, 32'h10, 32'h100, 32'd12, 2, 0, "backpressure");
    run(0, 2, 3, 32'h10, 32'h100, 32'd12, 1, 0, "random_ready");

    ra0 = bus1.o_read_addr;
    run(0, 0, 4, 32'h33, 32'h200, 32'd16, 0, 0, "zero_rows");
    chk("zero_rows_raddr_kept", 64'(bus1.o_read_addr), 64'(ra0));
    run(0, 3, 0, 32'h33, 32'h200, 32'd16, 0, 0, "zero_cols");

    run(1, 3, 1, 32'd1022, 32'h4000, 32'd4, 0, 0, "wrap_lat3");
    chk("wrap_final_raddr", 64'(bus3.o_read_addr), 64'd0);

    run(0, 2, 3, 32'h10, 32'h100, 32'd12, 0, 5, "start_busy");

    // Abort with reset in the middle of the 4th write while it is stalled.
    rmode[0] = 2; stall_idx[0] = 3; stall_len[0] = 100000; acc_base[0] = nacc[0];
    set_in(2, 3, 32'h10, 32'h100, 32'd12);
    @(posedge clk); #1; bus1.start = 1'b1;
    @(posedge clk); #1; bus1.start = 1'b0;
    n = 0;
    while (!((nacc[0] - acc_base[0]) == 3 && bus1.bram_w_en == 4'hF) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reached_4th_write", 64'(n < 300), 64'd1);
    @(posedge clk); #3;
    rst1_n = 1'b0;
    #1;
    chk("abort_en", 64'(bus1.bram_w_en), 64'd0);
    chk("abort_busy", 64'(bus1.busy), 64'd0);
    chk("abort_done", 64'(bus1.done), 64'd0);
    chk("abort_waddr", 64'(bus1.bram_w_addr), 64'd0);
    chk("abort_wdata", 64'(bus1.bram_w_data), 64'd0);
    chk("abort_raddr", 64'(bus1.o_read_addr), 64'd0);
    chk("abort_ridx", 64'(bus1.o_ram_idx), 64'd0);
    rmode[0] = 0;
    @(negedge clk); rst1_n = 1'b1;
    w0 = wq.size(); d0 = dn[0];
    repeat (30) @(posedge clk);
    chk("abort_no_writes", 64'(wq.size() - w0), 64'd0);
    chk("abort_no_done", 64'(dn[0] - d0), 64'd0);
    chk("abort_idle", 64'(bus1.busy), 64'd0);
    run(0, 2, 3, 32'h10, 32'h100, 32'd12, 0, 0, "post_reset");

    for (int it = 0; it < 6; it++) begin
      k    = it % 2;
      rows = int'($urandom_range(1, 3));
      cols = int'($urandom_range(1, ARRAY_M));
      ob   = $urandom_range(0, RAM_SIZE - 1);
      bb   = $urandom;
      st   = $urandom;
      run(k, rows, cols, ob, bb, st, int'($urandom_range(0, 1)), 0, $sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
